// File: rtl/seq_subtractor_32bit_if.sv
// ---------------------------------------------------------------------------
// seq_subtractor_32bit_if
// Operand/result bundle for the multi-cycle subtractor.
//   start        request pulse (taken only when the block is ready)
//   a, b, bin    minuend, subtrahend and borrow-in, sampled with start
//   busy         slices are being computed
//   done         one-cycle result-valid pulse
//   diff         WIDTH-bit result, held until the next accepted start
//   bout, zero,  borrow-out, zero and signed-overflow flags
//   ovf
// The master modport drives the request; the slave modport is the subtractor.
// ---------------------------------------------------------------------------
interface seq_subtractor_32bit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, zero, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, zero, ovf
  );
endinterface

// File: rtl/seq_subtractor_32bit.sv
// ---------------------------------------------------------------------------
// seq_subtractor_32bit
// Multi-cycle subtractor: diff = a - b - bin, one SLICE-bit slice per clock,
// least-significant slice first, borrow chained through a register.
// Latency NSLICE cycles from the accepting edge to done; a start presented in
// the done cycle is accepted back-to-back.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    seq_subtractor_32bit_if.slave: start/a/b/bin in,
//          busy/done/diff/bout/zero/ovf out
//
// Parameters: WIDTH (operand width, multiple of SLICE), SLICE (bits per clock).
//
// Build option: define SUB_SAT_EN for unsigned saturating mode (a final
// borrow forces diff to zero; bout stays set, ovf is taken from the
// unsaturated result).
// ---------------------------------------------------------------------------
module seq_subtractor_32bit #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  seq_subtractor_32bit_if.slave  bus
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);
  localparam logic [WIDTH-1:0] SMASK    = WIDTH'({SLICE{1'b1}});

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             borrow_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             zero_q;
  logic             ovf_q;

  logic             accept;
  logic             last;
  logic [31:0]      sh;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [SLICE-1:0] a_k;
  logic [SLICE-1:0] b_k;
  logic [SLICE:0]   sub_k;
  logic [WIDTH-1:0] diff_nxt;
  logic [WIDTH-1:0] diff_fin;
  logic             ovf_nxt;

`ifdef SUB_SAT_EN
  function automatic logic [WIDTH-1:0] sat_diff(input logic [WIDTH-1:0] d,
                                                input logic             brw);
    return brw ? '0 : d;
  endfunction
`endif

  // Slice datapath: pick slice cnt of the latched operands, subtract with the
  // running borrow and splice the result into the partial diff.
  always_comb begin
    accept   = bus.start && ((state == S_IDLE) || (state == S_DONE));
    last     = (cnt == LAST_CNT);
    sh       = 32'(cnt) * 32'(SLICE);
    a_sh     = a_q >> sh;
    b_sh     = b_q >> sh;
    a_k      = a_sh[SLICE-1:0];
    b_k      = b_sh[SLICE-1:0];
    // The extra top bit of sub_k is the borrow out of this slice.
    sub_k    = {1'b0, a_k} - {1'b0, b_k} - {{SLICE{1'b0}}, borrow_q};
    diff_nxt = (diff_q & ~(SMASK << sh)) | (WIDTH'(sub_k[SLICE-1:0]) << sh);
    // Overflow only possible when the operand signs differ.
    ovf_nxt  = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
               (diff_nxt[WIDTH-1] != a_q[WIDTH-1]);
`ifdef SUB_SAT_EN
    diff_fin = sat_diff(diff_nxt, sub_k[SLICE]);
`else
    diff_fin = diff_nxt;
`endif
  end

  // Control and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state)
        S_BUSY: begin
          diff_q   <= last ? diff_fin : diff_nxt;
          borrow_q <= sub_k[SLICE];
          cnt      <= cnt + 1'b1;
          if (last) begin
            // Flags change only here, from the completed result.
            bout_q <= sub_k[SLICE];
            zero_q <= (diff_fin == '0);
            ovf_q  <= ovf_nxt;
            cnt    <= '0;
            state  <= S_DONE;
          end
        end
        default: begin
          // IDLE and DONE both accept a new request.
          if (accept) begin
            borrow_q <= bus.bin;
            cnt      <= '0;
            state    <= S_BUSY;
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Operand latches are pure data and need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= bus.a;
      b_q <= bus.b;
    end
  end

  assign bus.busy = (state == S_BUSY);
  assign bus.done = (state == S_DONE);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.zero = zero_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_seq_subtractor_32bit.sv
module tb_seq_subtractor_32bit;
  localparam int WIDTH  = 32;
  localparam int SLICE  = 8;
  localparam int NSLICE = WIDTH / SLICE;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_subtractor_32bit_if #(.WIDTH(WIDTH)) bus();

  seq_subtractor_32bit #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [31:0] diff;
    logic        bout;
    logic        zero;
    logic        ovf;
    int          dcyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   last_acc = -100;
  int   next_ok = 0;
  logic [31:0] h_diff = '0;
  logic        h_bout = 1'b0;
  logic        h_zero = 1'b0;
  logic        h_ovf  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  function automatic exp_t sat(input exp_t e);
    exp_t r;
    r = e;
`ifdef SUB_SAT_EN
    if (r.bout) begin
      r.diff = '0;
      r.zero = 1'b1;
    end
`endif
    return r;
  endfunction

  // Reference: plain wide arithmetic on the whole words.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic bin);
    exp_t   e;
    longint r;
    e.bout = ({32'b0, a} < ({32'b0, b} + 64'(bin)));
    e.diff = a - b - 32'(bin);
    e.zero = (e.diff == 32'd0);
    r      = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
    e.ovf  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    e.dcyc = 0;
    return sat(e);
  endfunction

  // Drive one cycle of stimulus at the current negedge; record the expected
  // response if the request will be taken at the coming edge.
  task automatic apply(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic bin, input bit use_kat, input exp_t kat);
    exp_t e;
    bus.start = s;
    bus.a     = a;
    bus.b     = b;
    bus.bin   = bin;
    if (s && rst_n && (cyc + 1 >= next_ok)) begin
      e        = use_kat ? sat(kat) : model(a, b, bin);
      e.dcyc   = cyc + 1 + NSLICE;
      q.push_back(e);
      last_acc = cyc + 1;
      next_ok  = cyc + 1 + NSLICE + 1;
    end
  endtask

  task automatic issue_kat(input logic [31:0] a, input logic [31:0] b, input logic bin,
                           input logic [31:0] d, input logic bo, input logic z, input logic o);
    exp_t k;
    k.diff = d; k.bout = bo; k.zero = z; k.ovf = o; k.dcyc = 0;
    @(negedge clk);
    while (cyc + 1 < next_ok) @(negedge clk);
    apply(1'b1, a, b, bin, 1'b1, k);
    @(negedge clk);
    apply(1'b0, $urandom, $urandom, 1'($urandom), 1'b0, k);
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin : mon
    bit eb;
    bit ed;
    if (rst_n) begin
      eb = (cyc >= last_acc) && (cyc < last_acc + NSLICE);
      ed = (q.size() > 0) && (q[0].dcyc == cyc);
      chk("busy", 64'(bus.busy), 64'(eb));
      chk("done", 64'(bus.done), 64'(ed));
      if (ed) begin
        h_diff = q[0].diff;
        h_bout = q[0].bout;
        h_zero = q[0].zero;
        h_ovf  = q[0].ovf;
        void'(q.pop_front());
      end else if (q.size() > 0 && q[0].dcyc < cyc) begin
        void'(q.pop_front());
      end
      chk("bout", 64'(bus.bout), 64'(h_bout));
      chk("zero", 64'(bus.zero), 64'(h_zero));
      chk("ovf",  64'(bus.ovf),  64'(h_ovf));
      if (!eb) chk("diff", 64'(bus.diff), 64'(h_diff));
    end
  end

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_done"}, 64'(bus.done), 64'd0);
    chk({tag, "_diff"}, 64'(bus.diff), 64'd0);
    chk({tag, "_bout"}, 64'(bus.bout), 64'd0);
    chk({tag, "_zero"}, 64'(bus.zero), 64'd0);
    chk({tag, "_ovf"},  64'(bus.ovf),  64'd0);
  endtask

  initial begin
    exp_t dummy;
    int   e0;
    logic [31:0] ra;
    logic [31:0] rb;
    dummy = '{default: 0};
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;

    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;

    // Known answers.
    issue_kat(32'd5,          32'd3,          1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0);
    issue_kat(32'h00010000,   32'h00000001,   1'b0, 32'h0000FFFF, 1'b0, 1'b0, 1'b0);
    issue_kat(32'h00000000,   32'h00000001,   1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    issue_kat(32'h80000000,   32'h00000001,   1'b0, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1);
    issue_kat(32'hFFFFFFFF,   32'hFFFFFFFF,   1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    issue_kat(32'h12345678,   32'h12345678,   1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0);
    issue_kat(32'h00000000,   32'h80000000,   1'b0, 32'h80000000, 1'b1, 1'b0, 1'b1);

    // start re-asserted mid-operation with other operands must be ignored.
    issue_kat(32'd100, 32'd1, 1'b0, 32'd99, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 32'hDEADBEEF, 32'h1, 1'b1, 1'b0, dummy);
    @(negedge clk);
    apply(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, dummy);

    // start held high: back-to-back operations every NSLICE+1 cycles.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      apply(1'b1, $urandom, $urandom, 1'($urandom), 1'b0, dummy);
    end

    // Random traffic with operands changing every cycle.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = ra;
        1: ra = 32'h80000000;
        2: rb = 32'hFFFFFFFF;
        3: ra = '0;
        default: ;
      endcase
      apply(($urandom_range(0, 2) == 0), ra, rb, 1'($urandom), 1'b0, dummy);
    end
    @(negedge clk);
    apply(1'b0, '0, '0, 1'b0, 1'b0, dummy);

    // Reset in the middle of an operation.
    @(negedge clk);
    while (cyc + 1 < next_ok) @(negedge clk);
    apply(1'b1, 32'h55555555, 32'h11111111, 1'b0, 1'b0, dummy);
    e0 = cyc + 1;
    @(negedge clk);
    apply(1'b0, '0, '0, 1'b0, 1'b0, dummy);
    while (cyc < e0 + 2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    q.delete();
    last_acc = -100;
    next_ok  = 0;
    h_diff = '0; h_bout = 1'b0; h_zero = 1'b0; h_ovf = 1'b0;
    #1;
    check_zero_outputs("midrst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issue_kat(32'd10, 32'd4, 1'b0, 32'd6, 1'b0, 1'b0, 1'b0);

    // Drain, bounded.
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d results outstanding, expected 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_subtractor_32bit.md
Name: seq_subtractor_32bit

Overview:
- Multi-cycle 32-bit subtractor with borrow-in/borrow-out. Computes diff = a - b - bin, one SLICE-bit slice per clock, least-significant slice first, chaining the borrow through a register.
- It is the inverse operation of the team's 32-bit ripple adder. It sits beside that adder in the datapath lab and uses a start/done handshake so it can share operand buses.
- It also reports zero and signed-overflow flags for later ALU use.

Parameters:
- WIDTH, 32: operand and result width in bits. Must be a multiple of SLICE.
- SLICE, 8: bits subtracted per clock. NSLICE = WIDTH/SLICE cycles per operation.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse. Sampled only when the block is ready.
- a  input  WIDTH  minuend. Sampled with an accepted start.
- b  input  WIDTH  subtrahend. Sampled with an accepted start.
- bin  input  1  borrow-in. Sampled with an accepted start.
- busy  output  1  high while slices are being computed.
- done  output  1  one-cycle pulse: result valid.
- diff  output  WIDTH  result. Held until the next accepted start.
- bout  output  1  borrow-out; 1 iff a < b + bin (unsigned).
- zero  output  1  diff == 0.
- ovf  output  1  signed overflow: a[MSB] != b[MSB] and diff[MSB] != a[MSB].

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; busy = 0, done = 0.
  - diff = 0, bout = 0, zero = 0, ovf = 0.
  - Slice counter and borrow register = 0.
  - Any in-flight operation is discarded; no done is produced for it.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: start = 1 at edge T0 latches a, b, bin; borrow register = bin; counter = 0; next state BUSY; busy = 1 from T0.
  - BUSY: each edge computes slice k as {borrow_n, d_k} = a_k - b_k - borrow. Store d_k into diff[k*SLICE +: SLICE]; update borrow; increment counter.
  - BUSY exit: the edge processing slice NSLICE-1 (T_NSLICE, i.e. T4 by default) moves to DONE. At that same edge bout, zero and ovf are registered from the final values, busy drops and done rises.
  - DONE: lasts exactly one cycle. done = 1, busy = 0. Next state is IDLE, unless start = 1 in this cycle: then new operands are accepted and the next state is BUSY (back-to-back, one idle cycle saved).
- Latency: done is high in the cycle following edge T_NSLICE, i.e. NSLICE cycles after the accepting edge.
  - Throughput: one operation per NSLICE+1 cycles back-to-back.
- start while busy = 1 is ignored: no latch, no queue, and the operation in flight is unaffected.
- Input capture: a, b and bin may change freely after the accepting edge; the block uses only the latched copies.
- diff during BUSY: partial results are visible and are not guaranteed meaningful until done.
- diff/flags after DONE: held unchanged through IDLE until the next accepted start.
- zero, ovf and bout update only at the DONE transition, never per slice.
- Arithmetic is modulo 2^WIDTH. Borrow-out of the top slice is bout.
  - bin = 1 with a = b gives diff = all-ones, bout = 1.

Optional Feature:
- Macro: SUB_SAT_EN.
- Defined: unsigned saturating mode. When the final borrow is 1, diff is forced to 0 at the DONE transition; zero = 1, bout still = 1, ovf computed from the unsaturated result.
- Undefined: plain modulo result as above; no saturation logic is instantiated.

Test Plan:
- Basic subtract: a = 5, b = 3, bin = 0, start at T0 -> done pulses in the cycle after T4; diff = 0x00000002, bout = 0, zero = 0, ovf = 0; busy high for exactly 4 cycles.
- Cross-slice borrow:
  - a = 0x00010000, b = 0x00000001 -> diff = 0x0000FFFF, bout = 0.
  - a = 0, b = 1 -> diff = 0xFFFFFFFF, bout = 1.
  - With SUB_SAT_EN: diff = 0, zero = 1, bout = 1.
- Signed overflow and borrow-in:
  - a = 0x80000000, b = 1 -> diff = 0x7FFFFFFF, ovf = 1, bout = 0.
  - a = b = 0xFFFFFFFF, bin = 1 -> diff = 0xFFFFFFFF, bout = 1.
  - a = b = 0x12345678, bin = 0 -> zero = 1.
- Handshake:
  - start re-asserted mid-BUSY with different operands -> ignored; result is from the first operands.
  - start held high in the DONE cycle -> second operation accepted; its done arrives 5 cycles after the first done.
- Reset mid-operation: rst_n pulled low at T2 (asynchronously, between edges) -> all outputs 0 immediately and no done. After release, a fresh start with a = 10, b = 4 gives diff = 6 after 4 cycles.
